// File: rtl/vslc_pkg.sv
// ---------------------------------------------------------------------------
// vslc_pkg
// Shared definitions for the VSLC program-fetch path: the 25xx EEPROM READ
// opcode and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package vslc_pkg;

   localparam logic [7:0] EEPROM_READ_CMD = 8'h03;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_CMD,
      ST_ADDR,
      ST_READ,
      ST_HOLD,
      ST_CS_HIGH
   } fetch_state_t;

   // States in which SCK is allowed to toggle.
   function automatic logic is_shift_state(input fetch_state_t s);
      return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_READ);
   endfunction

endpackage

// File: rtl/vslc_spi_clkgen.sv
// ---------------------------------------------------------------------------
// vslc_spi_clkgen
// SCK phase timer. While i_run is high it alternates a low phase and a high
// phase, each SCK_DIV clk cycles long, starting with the low phase.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_run        timer enabled (held at start of low phase when low)
//   i_clr        restart at the start of a low phase on the next edge
//   o_high       current phase is the high phase
//   o_rise_stb   last cycle of a low phase (next edge starts high phase)
//   o_fall_stb   last cycle of a high phase (next edge starts low phase)
// ---------------------------------------------------------------------------
module vslc_spi_clkgen #(
   parameter int SCK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_run,
   input  logic i_clr,
   output logic o_high,
   output logic o_rise_stb,
   output logic o_fall_stb
);

   localparam logic [3:0] LAST_CNT = 4'(SCK_DIV - 1);

   logic [3:0] r_cnt;
   logic       r_high;
   logic       w_last;

   assign w_last = (r_cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_high <= 1'b0;
      end else if (!i_run || i_clr) begin
         r_cnt  <= '0;
         r_high <= 1'b0;
      end else if (w_last) begin
         r_cnt  <= '0;
         r_high <= ~r_high;
      end else begin
         r_cnt  <= r_cnt + 4'd1;
      end
   end

   // Strobes must not depend on i_clr: the caller derives i_clr from its
   // next-state logic, which in turn consumes these strobes.
   assign o_high     = r_high;
   assign o_rise_stb = i_run && !r_high && w_last;
   assign o_fall_stb = i_run &&  r_high && w_last;

endmodule

// File: rtl/vslc_spi_fetch.sv
// ---------------------------------------------------------------------------
// vslc_spi_fetch
// Streams a range of program bytes out of a 25xx SPI EEPROM (mode 0) using
// the READ command, handing them one at a time to the VSLC core through a
// valid/ready byte port. SPI clocking pauses while a byte waits for the core.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           begin a fetch (IDLE only) / terminate a fetch
//   start_addr, end_addr   inclusive byte range, may wrap through 16'hFFFF
//   byte_data/valid/addr   fetched byte, its address, and the valid flag
//   byte_ready             core accepts the byte
//   busy, done             not IDLE / one-cycle end-of-fetch pulse
//   spi_cs_n/sck/copi/cipo EEPROM SPI bus
// ---------------------------------------------------------------------------
module vslc_spi_fetch
   import vslc_pkg::*;
#(
   parameter int SCK_DIV = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] start_addr,
   input  logic [15:0] end_addr,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic [15:0] byte_addr,
   output logic        busy,
   output logic        done,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_copi,
   input  logic        spi_cipo
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   logic [23:0] r_shift;      // {command, address}, shifted out MSB first
   logic [7:0]  r_rx;
   logic [3:0]  r_bit;
   logic [15:0] r_end_addr;
   logic [15:0] r_byte_addr;
   logic [7:0]  r_byte_data;

   logic w_run, w_clr, w_sck_high, w_rise, w_fall, w_xfer;

   // The phase timer runs through every timed state, and restarts on each
   // state change so every state begins at the start of a low phase.
   assign w_run = (r_state != ST_IDLE) && (r_state != ST_HOLD);
   assign w_clr = (w_state_next != r_state);

   vslc_spi_clkgen #(
      .SCK_DIV    (SCK_DIV)
   ) u_clkgen (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_run      (w_run),
      .i_clr      (w_clr),
      .o_high     (w_sck_high),
      .o_rise_stb (w_rise),
      .o_fall_stb (w_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_xfer       = 1'b0;
      done         = 1'b0;
      busy         = (r_state != ST_IDLE);
      byte_valid   = (r_state == ST_HOLD);
      spi_cs_n     = (r_state == ST_IDLE) || (r_state == ST_CS_HIGH);
      spi_sck      = w_sck_high && is_shift_state(r_state);
      spi_copi     = ((r_state == ST_CMD) || (r_state == ST_ADDR)) && r_shift[23];

      // CS_HIGH is already the abort destination; letting abort restart it
      // would only stretch the deselect time.
      if (abort && (r_state != ST_IDLE) && (r_state != ST_CS_HIGH)) begin
         w_state_next = ST_CS_HIGH;
      end else begin
         case (r_state)
            ST_IDLE:     if (start && !abort)            w_state_next = ST_CS_SETUP;
            ST_CS_SETUP: if (w_rise)                     w_state_next = ST_CMD;
            ST_CMD:      if (w_fall && r_bit == 4'd7)    w_state_next = ST_ADDR;
            ST_ADDR:     if (w_fall && r_bit == 4'd15)   w_state_next = ST_READ;
            ST_READ:     if (w_fall && r_bit == 4'd7)    w_state_next = ST_HOLD;
            ST_HOLD: begin
               if (byte_ready) begin
                  w_xfer       = 1'b1;
                  w_state_next = (r_byte_addr == r_end_addr) ? ST_CS_HIGH : ST_READ;
               end
            end
            ST_CS_HIGH: begin
               if (w_fall) begin
                  done         = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end
            default:                                     w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift     <= '0;
         r_rx        <= '0;
         r_bit       <= '0;
         r_end_addr  <= '0;
         r_byte_addr <= '0;
         r_byte_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_state_next == ST_CS_SETUP) begin
                  r_end_addr  <= end_addr;
                  r_byte_addr <= start_addr;
                  r_shift     <= {EEPROM_READ_CMD, start_addr};
                  r_bit       <= '0;
               end
            end
            ST_CMD, ST_ADDR: begin
               if (w_fall) begin
                  r_shift <= {r_shift[22:0], 1'b0};
                  r_bit   <= (w_state_next == r_state) ? r_bit + 4'd1 : 4'd0;
               end
            end
            ST_READ: begin
               if (w_rise) r_rx <= {r_rx[6:0], spi_cipo};
               if (w_fall) r_bit <= (w_state_next == r_state) ? r_bit + 4'd1 : 4'd0;
               if (w_state_next == ST_HOLD) r_byte_data <= r_rx;
            end
            ST_HOLD: begin
               // 16-bit increment wraps FFFF -> 0000 on its own.
               if (w_xfer && w_state_next == ST_READ) r_byte_addr <= r_byte_addr + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign byte_data = r_byte_data;
   assign byte_addr = r_byte_addr;

endmodule

// File: tb/tb_vslc_spi_fetch.sv
`timescale 1ns/1ps
module tb_vslc_spi_fetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0, abort = 1'b0, byte_ready = 1'b0;
   logic [15:0] start_addr = '0, end_addr = '0;
   logic [7:0]  byte_data;
   logic        byte_valid, busy, done, spi_cs_n, spi_sck, spi_copi;
   logic [15:0] byte_addr;
   logic        spi_cipo = 1'b0;

   // second instance for the SCK_DIV=3 timing checks
   logic        s3_start = 1'b0, s3_abort = 1'b0, s3_ready = 1'b0, s3_cipo = 1'b0;
   logic [15:0] s3_start_addr = '0, s3_end_addr = '0;
   logic [7:0]  s3_data;
   logic [15:0] s3_addr;
   logic        s3_valid, s3_busy, s3_done, s3_cs_n, s3_sck, s3_copi;

   always #5 clk = ~clk;

   vslc_spi_fetch #(.SCK_DIV(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .start_addr(start_addr), .end_addr(end_addr),
      .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .byte_addr(byte_addr), .busy(busy), .done(done),
      .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_copi(spi_copi), .spi_cipo(spi_cipo)
   );

   vslc_spi_fetch #(.SCK_DIV(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(s3_start), .abort(s3_abort),
      .start_addr(s3_start_addr), .end_addr(s3_end_addr),
      .byte_data(s3_data), .byte_valid(s3_valid), .byte_ready(s3_ready),
      .byte_addr(s3_addr), .busy(s3_busy), .done(s3_done),
      .spi_cs_n(s3_cs_n), .spi_sck(s3_sck), .spi_copi(s3_copi), .spi_cipo(s3_cipo)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- 25xx EEPROM model (mode 0) ----------------
   int          m_bits = 0;
   int          cs_falls = 0;
   logic [23:0] m_hdr = '0;

   function automatic logic [7:0] ee_byte(input logic [15:0] a);
      logic [7:0] v;
      if (a == 16'h0010) return 8'hA5;
      v = 8'(a[7:0] * 8'd7) + 8'h31;
      return v ^ a[15:8];
   endfunction

   always @(negedge spi_cs_n) begin
      m_bits = 0;
      m_hdr  = '0;
      cs_falls++;
   end

   always @(posedge spi_sck) begin
      if (!spi_cs_n) begin
         if (m_bits < 24) m_hdr = {m_hdr[22:0], spi_copi};
         m_bits++;
      end
   end

   always @(negedge spi_sck) begin : ee_out
      int         k;
      logic [7:0] d;
      if (!spi_cs_n && m_bits >= 24) begin
         k = m_bits - 24;
         d = ee_byte(m_hdr[15:0] + 16'(k / 8));
         spi_cipo = d[7 - (k % 8)];
      end
   end

   // ---------------- fetch runner ----------------
   logic [15:0] ex_addr [0:2];
   logic [7:0]  ex_data [0:2];

   task automatic run_fetch(input string name, input logic [15:0] sa, input logic [15:0] ea,
                            input int n_exp, input int stall_idx, input int stall_len);
      int         got, k, k_valid, k_xfer, k_done, stall_left, cs0;
      logic [7:0] held;
      logic       stall_ok;
      got = 0; k_valid = 0; k_xfer = 0; k_done = 0;
      stall_left = stall_len; stall_ok = 1'b1; held = '0;
      cs0 = cs_falls;
      start_addr = sa; end_addr = ea; byte_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      k = 1;
      while (k_done == 0 && k < 3000) begin
         if (done) begin
            k_done = k;
         end else if (byte_valid) begin
            if (k_valid == 0) k_valid = k;
            if (got == stall_idx && stall_left > 0) begin
               if (stall_left == stall_len) held = byte_data;
               else if (byte_data !== held) stall_ok = 1'b0;
               if (spi_sck !== 1'b0) stall_ok = 1'b0;
               byte_ready = 1'b0;
               stall_left--;
            end else begin
               byte_ready = 1'b1;
               $display("[%0t] %s byte %0d addr=%h data=%h", $time, name, got, byte_addr, byte_data);
               if (got < 3) begin
                  check({name, "_addr"}, 32'(byte_addr), 32'(ex_addr[got]));
                  check({name, "_data"}, 32'(byte_data), 32'(ex_data[got]));
               end
               got++;
               k_xfer = k;
            end
         end
         if (k_done == 0) begin
            tick();
            k++;
         end
      end
      check({name, "_done_seen"}, 32'(k_done != 0), 32'd1);
      check({name, "_first_valid_cycle"}, 32'(k_valid), 32'd66);
      check({name, "_byte_count"}, 32'(got), 32'(n_exp));
      check({name, "_done_after_xfer"}, 32'(k_done - k_xfer), 32'd2);
      check({name, "_copi_header"}, 32'(m_hdr), {8'h00, 8'h03, sa});
      check({name, "_cs_windows"}, 32'(cs_falls - cs0), 32'd1);
      if (stall_len > 0) check({name, "_stall_hold"}, 32'(stall_ok), 32'd1);
      tick();
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_idle_cs_n"}, 32'(spi_cs_n), 32'd1);
   endtask

   initial begin : main
      int k, run, first_high, low_run;
      logic prev;

      // ---- reset state (checked before any clk edge) ----
      #2 rst_n = 1'b0;
      #1;
      check("rst_cs_n", 32'(spi_cs_n), 32'd1);
      check("rst_sck", 32'(spi_sck), 32'd0);
      check("rst_copi", 32'(spi_copi), 32'd0);
      check("rst_valid", 32'(byte_valid), 32'd0);
      check("rst_data", 32'(byte_data), 32'd0);
      check("rst_addr", 32'(byte_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // ---- single byte ----
      ex_addr[0] = 16'h0010; ex_data[0] = 8'hA5;
      run_fetch("single", 16'h0010, 16'h0010, 1, -1, 0);

      // ---- backpressure on byte 1 ----
      ex_addr[0] = 16'h0000; ex_data[0] = 8'h31;
      ex_addr[1] = 16'h0001; ex_data[1] = 8'h38;
      ex_addr[2] = 16'h0002; ex_data[2] = 8'h3F;
      run_fetch("bp", 16'h0000, 16'h0002, 3, 1, 10);

      // ---- wrap through FFFF ----
      ex_addr[0] = 16'hFFFF; ex_data[0] = 8'hD5;
      ex_addr[1] = 16'h0000; ex_data[1] = 8'h31;
      ex_addr[2] = 16'h0001; ex_data[2] = 8'h38;
      run_fetch("wrap", 16'hFFFF, 16'h0001, 3, -1, 0);

      // ---- abort mid-ADDR (cycle 30) ----
      start_addr = 16'h0100; end_addr = 16'h0105; byte_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (29) tick();
      check("abort_addr_cs_low", 32'(spi_cs_n), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_addr_cs_high", 32'(spi_cs_n), 32'd1);
      check("abort_addr_sck", 32'(spi_sck), 32'd0);
      check("abort_addr_no_done_yet", 32'(done), 32'd0);
      tick();
      check("abort_addr_done", 32'(done), 32'd1);
      check("abort_addr_cs_hold", 32'(spi_cs_n), 32'd1);
      tick();
      check("abort_addr_idle", 32'(busy), 32'd0);
      $display("[%0t] abort in ADDR complete", $time);

      // ---- abort in HOLD with byte_ready and start in the same cycle ----
      start_addr = 16'h0200; end_addr = 16'h0203; byte_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      k = 1;
      while (!byte_valid && k < 200) begin
         tick();
         k++;
      end
      check("abort_hold_valid_cycle", 32'(k), 32'd66);
      abort = 1'b1; byte_ready = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; byte_ready = 1'b0; start = 1'b0;
      check("abort_hold_valid_drop", 32'(byte_valid), 32'd0);
      check("abort_hold_cs_high", 32'(spi_cs_n), 32'd1);
      check("abort_hold_no_xfer_addr", 32'(byte_addr), 32'h0200);
      tick();
      check("abort_hold_done", 32'(done), 32'd1);
      tick();
      check("abort_hold_idle", 32'(busy), 32'd0);
      tick();
      check("abort_hold_start_ignored", 32'(busy), 32'd0);
      $display("[%0t] abort in HOLD complete", $time);

      // ---- asynchronous reset during READ ----
      start_addr = 16'h0000; end_addr = 16'h0000; byte_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (54) tick();
      check("arst_pre_cs_low", 32'(spi_cs_n), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      check("arst_cs_n", 32'(spi_cs_n), 32'd1);
      check("arst_valid", 32'(byte_valid), 32'd0);
      check("arst_sck", 32'(spi_sck), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("arst_stay_idle", 32'(busy), 32'd0);
      check("arst_stay_cs_high", 32'(spi_cs_n), 32'd1);
      $display("[%0t] async reset during READ complete", $time);

      // ---- SCK_DIV = 3 latency and SCK half-periods ----
      s3_start_addr = 16'h0040; s3_end_addr = 16'h0040; s3_ready = 1'b1; s3_start = 1'b1;
      tick();
      s3_start = 1'b0;
      k = 1; run = 0; prev = 1'b0; first_high = 0; low_run = 0;
      while (!s3_valid && k < 400) begin
         if (s3_sck === prev) begin
            run++;
         end else begin
            if (prev == 1'b1 && first_high == 0) first_high = run;
            else if (prev == 1'b0 && first_high != 0 && low_run == 0) low_run = run;
            run = 1;
            prev = s3_sck;
         end
         tick();
         k++;
      end
      check("div3_first_valid_cycle", 32'(k), 32'd196);
      check("div3_sck_high_len", 32'(first_high), 32'd3);
      check("div3_sck_low_len", 32'(low_run), 32'd3);
      check("div3_hold_sck_low", 32'(s3_sck), 32'd0);
      k = 0;
      while (!s3_done && k < 50) begin
         tick();
         k++;
      end
      check("div3_done_after_xfer", 32'(k), 32'd6);
      $display("[%0t] SCK_DIV=3 fetch complete", $time);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
